// File: rtl/udma_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udma_uart_pkg
// Description : Types and helpers shared by the UART RX packer and its
//               idle-timeout sub-module. It provides the datasize encoding,
//               the packer FSM state encoding, and the datasize-to-bytes
//               mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package udma_uart_pkg;

    typedef enum logic [1:0] {
        DS_BYTE = 2'b00,
        DS_HALF = 2'b01,
        DS_WORD = 2'b10
    } datasize_e;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } packer_state_e;

    // The reserved encoding 11 is treated as a full word.
    function automatic datasize_e ds_normalize(input logic [1:0] ds);
        case (ds)
            2'b00:   return DS_BYTE;
            2'b01:   return DS_HALF;
            default: return DS_WORD;
        endcase
    endfunction

    // Returns the number of bytes per transfer (N) for a datasize.
    function automatic logic [2:0] ds_to_nbytes(input logic [1:0] ds);
        case (ds)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage : udma_uart_pkg
`default_nettype wire

// File: rtl/udma_uart_rx_timeout.sv
`default_nettype none
// ============================================================================
// Module      : udma_uart_rx_timeout
// Description : Idle counter for the RX packer. It counts cycles in which a
//               partial word waits with no new byte, and it pulses event_o in
//               the cycle where the count reaches cfg_timeout_i. The counter
//               saturates at all-ones. A threshold of 0 disables the event.
// Ports       : sys_clk_i, rstn_i (async, active-low)
//               clr_i         - synchronous clear
//               tick_i        - idle cycle qualifier; when low the count clears
//               cfg_timeout_i - threshold in idle cycles
//               event_o       - one-cycle expiry pulse
// Revision    : 1.0 - initial release
// ============================================================================
module udma_uart_rx_timeout
    import udma_uart_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     sys_clk_i,
    input  logic                     rstn_i,
    input  logic                     clr_i,
    input  logic                     tick_i,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout_i,
    output logic                     event_o
);

    logic [TIMEOUT_WIDTH-1:0] timer_q;
    logic [TIMEOUT_WIDTH-1:0] timer_d;

    // Any non-idle cycle (an accepted byte, or no partial word held) restarts
    // the count.
    always_comb begin
        timer_d = timer_q;
        if (clr_i || !tick_i) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // timer_q holds the count of idle cycles already completed. The current
    // idle cycle is therefore cycle number timer_q + 1.
    assign event_o = tick_i && (cfg_timeout_i != '0) &&
                     (timer_q == cfg_timeout_i - 1'b1);

endmodule : udma_uart_rx_timeout
`default_nettype wire

// File: rtl/udma_uart_rx_packer.sv
`default_nettype none
// ============================================================================
// Module      : udma_uart_rx_packer
// Description : Packs the received UART byte stream little-endian into
//               8/16/32-bit uDMA transfers. Partial words drain as single
//               bytes on flush_i, on a datasize change, or on an idle
//               timeout. The timeout is built only when the macro
//               UDMA_UART_RX_TIMEOUT_EN is defined.
// Ports       : sys_clk_i, rstn_i (async, active-low)
//               cfg_datasize_i, cfg_timeout_i, cfg_clr_i, flush_i
//               in_data_i/in_valid_i/in_ready_o     - byte input
//               out_data_o/out_datasize_o/out_valid_o/out_ready_i - output
//               timeout_event_o, byte_cnt_o         - status
// Revision    : 1.0 - initial release
// ============================================================================
module udma_uart_rx_packer
    import udma_uart_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     sys_clk_i,
    input  logic                     rstn_i,
    input  logic [1:0]               cfg_datasize_i,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout_i,
    input  logic                     cfg_clr_i,
    input  logic                     flush_i,
    input  logic [7:0]               in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [31:0]              out_data_o,
    output logic [1:0]               out_datasize_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     timeout_event_o,
    output logic [2:0]               byte_cnt_o
);

    packer_state_e state_q, state_d;
    datasize_e     ds_prev_q, ds_prev_d;
    logic [31:0]   acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   out_data_q, out_data_d;
    logic [1:0]    out_ds_q, out_ds_d;
    logic          out_valid_q, out_valid_d;

    datasize_e     ds_norm;
    logic [2:0]    nbytes;
    logic          accept;
    logic          slot_free;
    logic [31:0]   acc_fill;
    logic [2:0]    cnt_fill;
    logic          word_done;
    logic          partial;
    logic          ds_changed;
    logic          flush_start;
    logic          timeout_hit;

    assign ds_norm   = ds_normalize(cfg_datasize_i);
    assign nbytes    = ds_to_nbytes(cfg_datasize_i);
    assign accept    = in_valid_i && in_ready_o;
    assign slot_free = !out_valid_q || out_ready_i;

    // Place an accepted byte into the accumulator before any flush decision,
    // so a flush that arrives with a byte still includes that byte.
    always_comb begin
        acc_fill = acc_q;
        cnt_fill = cnt_q;
        if (accept) begin
            acc_fill[{cnt_q[1:0], 3'b000} +: 8] = in_data_i;
            cnt_fill                            = cnt_q + 3'd1;
        end
    end

    assign word_done  = (state_q == ST_FILL) && (cnt_fill >= nbytes);
    assign partial    = (cnt_fill != 3'd0) && (cnt_fill < nbytes);
    // Only bytes held from earlier cycles make a datasize change relevant.
    assign ds_changed = (ds_norm != ds_prev_q) && (cnt_q != 3'd0);
    assign flush_start = (state_q == ST_FILL) && partial &&
                         (flush_i || timeout_hit || ds_changed);

`ifdef UDMA_UART_RX_TIMEOUT_EN
    logic timer_tick;
    logic timeout_raw;

    assign timer_tick = (state_q == ST_FILL) && (cnt_q != 3'd0) &&
                        (cnt_q < nbytes) && !accept;

    udma_uart_rx_timeout #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .sys_clk_i     (sys_clk_i),
        .rstn_i        (rstn_i),
        .clr_i         (cfg_clr_i),
        .tick_i        (timer_tick),
        .cfg_timeout_i (cfg_timeout_i),
        .event_o       (timeout_raw)
    );

    assign timeout_hit = timeout_raw && !cfg_clr_i;
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout_i;
    assign timeout_hit    = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (cfg_clr_i) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL:  if (flush_start) state_d = ST_FLUSH;
                ST_FLUSH: if (slot_free && cnt_q <= 3'd1) state_d = ST_FILL;
                default:  state_d = ST_FILL;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready_o = (state_q == ST_FILL) && (cnt_q < nbytes);
    end

    // Datapath: accumulator, count, and the one-entry output register
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_ds_d    = out_ds_q;
        out_valid_d = out_valid_q && !out_ready_i;
        ds_prev_d   = ds_norm;

        if (cfg_clr_i) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_data_d  = '0;
            out_ds_d    = DS_BYTE;
            out_valid_d = 1'b0;
        end else if (state_q == ST_FILL) begin
            acc_d = acc_fill;
            cnt_d = cnt_fill;
            // A completed word waits in the accumulator until the slot frees.
            if (word_done && slot_free) begin
                out_data_d  = acc_fill;
                out_ds_d    = ds_norm;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end
        end else if (slot_free) begin
            // The right shift fills with zeros, so the accumulator is clean
            // again once the count reaches 0.
            out_data_d  = {24'd0, acc_q[7:0]};
            out_ds_d    = DS_BYTE;
            out_valid_d = 1'b1;
            acc_d       = {8'd0, acc_q[31:8]};
            cnt_d       = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_ds_q    <= DS_BYTE;
            out_valid_q <= 1'b0;
            ds_prev_q   <= DS_BYTE;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_ds_q    <= out_ds_d;
            out_valid_q <= out_valid_d;
            ds_prev_q   <= ds_prev_d;
        end
    end

    assign out_data_o      = out_data_q;
    assign out_datasize_o  = out_ds_q;
    assign out_valid_o     = out_valid_q;
    assign byte_cnt_o      = cnt_q;
    assign timeout_event_o = timeout_hit;

endmodule : udma_uart_rx_packer
`default_nettype wire

// File: tb/tb_udma_uart_rx_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_udma_uart_rx_packer
// Description : Directed self-checking bench for udma_uart_rx_packer. The
//               timeout scenario adapts to UDMA_UART_RX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udma_uart_rx_packer;

    logic        sys_clk_i = 1'b0;
    logic        rstn_i;
    logic [1:0]  cfg_datasize_i;
    logic [15:0] cfg_timeout_i;
    logic        cfg_clr_i;
    logic        flush_i;
    logic [7:0]  in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic [1:0]  out_datasize_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        timeout_event_o;
    logic [2:0]  byte_cnt_o;

    int checks   = 0;
    int failures = 0;

    udma_uart_rx_packer #(.TIMEOUT_WIDTH(16)) dut (
        .sys_clk_i       (sys_clk_i),
        .rstn_i          (rstn_i),
        .cfg_datasize_i  (cfg_datasize_i),
        .cfg_timeout_i   (cfg_timeout_i),
        .cfg_clr_i       (cfg_clr_i),
        .flush_i         (flush_i),
        .in_data_i       (in_data_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .out_data_o      (out_data_o),
        .out_datasize_o  (out_datasize_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .timeout_event_o (timeout_event_o),
        .byte_cnt_o      (byte_cnt_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    // Advance to 1 ns after the next rising edge, where the bench drives and samples.
    task automatic step();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; cfg_datasize_i = 2'b10; cfg_timeout_i = 16'd20;
        cfg_clr_i = 1'b0; flush_i = 1'b0; in_data_i = 8'h00;
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        #2;
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== 32'h0 || out_datasize_o !== 2'b00 ||
            byte_cnt_o !== 3'd0 || in_ready_o !== 1'b1 || timeout_event_o !== 1'b0) begin
            failures++;
            $display("FAIL reset: valid=%b data=%h ds=%b cnt=%0d rdy=%b ev=%b required 0 0 00 0 1 0",
                     out_valid_o, out_data_o, out_datasize_o, byte_cnt_o, in_ready_o, timeout_event_o);
        end
        repeat (3) step();
        rstn_i = 1'b1;
        step();
    endtask

    task automatic test_word_pack();
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        cfg_datasize_i = 2'b10; out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_i = b[i]; in_valid_i = 1'b1;
            checks++;
            if (out_valid_o !== 1'b0) begin
                failures++; $display("FAIL word_early_valid: byte %0d valid=%b required 0", i, out_valid_o);
            end
            step();
        end
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h44332211 || out_datasize_o !== 2'b10) begin
            failures++;
            $display("FAIL word_out: valid=%b data=%h ds=%b required 1 44332211 10",
                     out_valid_o, out_data_o, out_datasize_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b0 || byte_cnt_o !== 3'd0) begin
            failures++; $display("FAIL word_drop: valid=%b cnt=%0d required 0 0", out_valid_o, byte_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        cfg_datasize_i = 2'b01; out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data_i = b[i]; in_valid_i = 1'b1;
            step();
        end
        in_data_i = b[4];
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h0000BBAA || out_datasize_o !== 2'b01) begin
            failures++;
            $display("FAIL bp_hold: valid=%b data=%h ds=%b required 1 0000bbaa 01",
                     out_valid_o, out_data_o, out_datasize_o);
        end
        checks++;
        if (byte_cnt_o !== 3'd2 || in_ready_o !== 1'b0) begin
            failures++; $display("FAIL bp_full: cnt=%0d rdy=%b required 2 0", byte_cnt_o, in_ready_o);
        end
        step();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h0000DDCC || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_second: valid=%b data=%h rdy=%b required 1 0000ddcc 1",
                     out_valid_o, out_data_o, in_ready_o);
        end
        step();
        in_valid_i = 1'b0;
        checks++;
        if (byte_cnt_o !== 3'd1) begin
            failures++; $display("FAIL bp_ee_accept: cnt=%0d required 1", byte_cnt_o);
        end
        out_ready_i = 1'b1; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h000000EE || out_datasize_o !== 2'b00) begin
            failures++;
            $display("FAIL bp_drain: valid=%b data=%h ds=%b required 1 000000ee 00",
                     out_valid_o, out_data_o, out_datasize_o);
        end
        step();
    endtask

    task automatic test_timeout();
        logic [7:0] b [3] = '{8'h01, 8'h02, 8'h03};
        logic [7:0] e;
        cfg_datasize_i = 2'b10; cfg_timeout_i = 16'd20; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data_i = b[i]; in_valid_i = 1'b1;
            step();
        end
        in_valid_i = 1'b0;
`ifdef UDMA_UART_RX_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            checks++;
            if (timeout_event_o !== (k == 20)) begin
                failures++;
                $display("FAIL timeout_pulse: idle cycle %0d event=%b required %b", k, timeout_event_o, (k == 20));
            end
            step();
        end
`else
        for (int k = 1; k <= 30; k++) begin
            checks++;
            if (timeout_event_o !== 1'b0 || byte_cnt_o !== 3'd3) begin
                failures++;
                $display("FAIL no_timeout: idle cycle %0d event=%b cnt=%0d required 0 3", k, timeout_event_o, byte_cnt_o);
            end
            step();
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
`endif
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
            failures++; $display("FAIL to_flush_entry: rdy=%b valid=%b required 0 0", in_ready_o, out_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            e = b[i];
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== {24'd0, e} || out_datasize_o !== 2'b00) begin
                failures++;
                $display("FAIL to_byte%0d: valid=%b data=%h ds=%b required 1 %h 00",
                         i, out_valid_o, out_data_o, out_datasize_o, {24'd0, e});
            end
        end
        step();
        checks++;
        if (out_valid_o !== 1'b0 || byte_cnt_o !== 3'd0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL to_done: valid=%b cnt=%0d rdy=%b required 0 0 1", out_valid_o, byte_cnt_o, in_ready_o);
        end
    endtask

    task automatic test_flush_with_byte();
        cfg_datasize_i = 2'b10; out_ready_i = 1'b1;
        in_data_i = 8'h5A; in_valid_i = 1'b1;
        step();
        in_data_i = 8'hA5; flush_i = 1'b1;
        step();
        in_valid_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b0 || byte_cnt_o !== 3'd2 || out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL fl_entry: rdy=%b cnt=%0d valid=%b required 0 2 0", in_ready_o, byte_cnt_o, out_valid_o);
        end
        step();
        checks++;
        if (out_data_o !== 32'h5A || out_datasize_o !== 2'b00 || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL fl_first: data=%h ds=%b valid=%b rdy=%b required 0000005a 00 1 0",
                     out_data_o, out_datasize_o, out_valid_o, in_ready_o);
        end
        step();
        checks++;
        if (out_data_o !== 32'hA5 || out_valid_o !== 1'b1 || byte_cnt_o !== 3'd0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL fl_second: data=%h valid=%b cnt=%0d rdy=%b required 000000a5 1 0 1",
                     out_data_o, out_valid_o, byte_cnt_o, in_ready_o);
        end
        step();
    endtask

    task automatic test_datasize_change();
        cfg_datasize_i = 2'b10; out_ready_i = 1'b1;
        in_data_i = 8'h77; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0; cfg_datasize_i = 2'b01;
        step();
        step();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h77 || out_datasize_o !== 2'b00 || byte_cnt_o !== 3'd0) begin
            failures++;
            $display("FAIL ds_change: valid=%b data=%h ds=%b cnt=%0d required 1 00000077 00 0",
                     out_valid_o, out_data_o, out_datasize_o, byte_cnt_o);
        end
        step();
    endtask

    task automatic test_clear();
        logic [7:0] b [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        logic [7:0] c [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        cfg_datasize_i = 2'b10; out_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_data_i = b[i]; in_valid_i = 1'b1;
            step();
        end
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h04030201 || byte_cnt_o !== 3'd3) begin
            failures++;
            $display("FAIL clr_pre: valid=%b data=%h cnt=%0d required 1 04030201 3", out_valid_o, out_data_o, byte_cnt_o);
        end
        cfg_clr_i = 1'b1;
        step();
        cfg_clr_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || byte_cnt_o !== 3'd0 || out_data_o !== 32'h0) begin
            failures++;
            $display("FAIL clr_post: valid=%b cnt=%0d data=%h required 0 0 00000000", out_valid_o, byte_cnt_o, out_data_o);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_i = c[i]; in_valid_i = 1'b1;
            step();
        end
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h40302010 || out_datasize_o !== 2'b10) begin
            failures++;
            $display("FAIL clr_burst: valid=%b data=%h ds=%b required 1 40302010 10", out_valid_o, out_data_o, out_datasize_o);
        end
        step();
    endtask

    task automatic test_reset_in_flush();
        logic [7:0] b [3] = '{8'h01, 8'h02, 8'h03};
        cfg_datasize_i = 2'b10; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data_i = b[i]; in_valid_i = 1'b1; flush_i = (i == 2);
            step();
        end
        in_valid_i = 1'b0; flush_i = 1'b0;
        step();
        checks++;
        if (out_data_o !== 32'h01 || byte_cnt_o !== 3'd2) begin
            failures++; $display("FAIL rf_pre: data=%h cnt=%0d required 00000001 2", out_data_o, byte_cnt_o);
        end
        rstn_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== 32'h0 || out_datasize_o !== 2'b00 ||
            byte_cnt_o !== 3'd0 || in_ready_o !== 1'b1 || timeout_event_o !== 1'b0) begin
            failures++;
            $display("FAIL rf_reset: valid=%b data=%h ds=%b cnt=%0d rdy=%b ev=%b required 0 0 00 0 1 0",
                     out_valid_o, out_data_o, out_datasize_o, byte_cnt_o, in_ready_o, timeout_event_o);
        end
        step();
        rstn_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_valid_o !== 1'b0 || byte_cnt_o !== 3'd0) begin
                failures++;
                $display("FAIL rf_after: cycle %0d valid=%b cnt=%0d required 0 0", k, out_valid_o, byte_cnt_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_pack();
        test_backpressure();
        test_timeout();
        test_flush_with_byte();
        test_datasize_change();
        test_clear();
        test_reset_in_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_udma_uart_rx_packer
`default_nettype wire

// File: doc/udma_uart_rx_packer.md
# udma_uart_rx_packer

- Sits between the UART RX clock-domain-crossing FIFO output (byte stream in sys_clk_i domain) and the uDMA RX channel.
- Packs received bytes little-endian into 8/16/32-bit transfers according to the configured datasize.
- Drains partial words as single bytes on an explicit flush or on an idle timeout, so short messages reach L2 without waiting for a full word.

## Interface
- TIMEOUT_WIDTH, 16, width of the idle-timeout counter and its threshold.
- sys_clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- cfg_datasize_i  in  2  transfer size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- cfg_timeout_i  in  TIMEOUT_WIDTH  idle cycles before a partial word is flushed; 0 disables the timeout.
- cfg_clr_i  in  1  synchronous clear of all packer state.
- flush_i  in  1  single-cycle request to drain the partial word.
- in_data_i  in  8  received byte.
- in_valid_i  in  1  byte valid.
- in_ready_o  out  1  byte accepted when in_valid_i and in_ready_o are both high.
- out_data_o  out  32  packed data; the first byte is in [7:0]; unused upper bits are 0.
- out_datasize_o  out  2  size of the current transfer.
- out_valid_o  out  1  transfer valid.
- out_ready_i  in  1  channel accepts the transfer.
- timeout_event_o  out  1  one-cycle pulse when a timeout flush starts.
- byte_cnt_o  out  3  bytes currently held in the accumulator (0..4).

## Operation
- N = 1, 2 or 4 bytes, taken from cfg_datasize_i.
- State is held in a 32-bit accumulator, a byte count, a one-entry output register and the FSM.
- FSM states:
  - FILL: accept bytes.
  - FLUSH: emit accumulated bytes one at a time with datasize 00, lowest byte first. Shift the accumulator right by 8 and decrement the count per emitted byte. Return to FILL when the count reaches 0.
- An accepted byte is written at byte lane = count, then the count increments.
- When the count reaches N:
  - If the output slot is free (out_valid_o low, or out_ready_i high this cycle), the word is loaded into the output register with datasize = cfg_datasize_i and the count returns to 0.
  - Otherwise the word stays in the accumulator with count = N.
- in_ready_o = state FILL and count < N.
- Output register follows valid/ready rules: data and datasize are stable while out_valid_o is high and out_ready_i is low. out_valid_o drops only after a handshake.
- FLUSH entry from FILL with 0 < count < N on any of:
  - flush_i;
  - timeout expiry;
  - cfg_datasize_i changing with a partial word held.
- flush_i with count 0, or while already in FLUSH, is ignored.
- Simultaneous flush_i and accepted byte: the byte is included first. If it completes the word, the normal word path is used and the flush is a no-op.
- cfg_clr_i has highest priority. It zeroes the accumulator, count, timer and output register, drops out_valid_o, and returns to FILL.
- Reset values:
  - out_data_o 0, out_datasize_o 00, out_valid_o 0;
  - timeout_event_o 0, byte_cnt_o 0;
  - in_ready_o 1;
  - state FILL.
- A reset in the middle of FLUSH discards all held bytes.

## Timing
- Word-completing byte accepted in cycle t → out_valid_o high at t+1 (given a free slot).
- Sustained throughput: 1 byte/cycle in; one transfer per N cycles out.
- FLUSH emits one byte per cycle while out_ready_i stays high. The first flushed byte is valid the cycle after FLUSH entry.
- Timer behaviour:
  - Cleared on every accepted byte.
  - Increments each FILL cycle with 0 < count < N and no accept.
  - On reaching cfg_timeout_i: timeout_event_o pulses for that cycle and the FSM enters FLUSH at the next edge.
- Timer width arithmetic saturates at all-ones and never wraps.

## Configuration
- UDMA_UART_RX_TIMEOUT_EN defined: idle-timeout logic is present, as described above.
- Undefined:
  - Timer removed and cfg_timeout_i ignored.
  - timeout_event_o tied to 0.
  - Partial words drain only on flush_i, datasize change, or cfg_clr_i (which discards them).

## Structure
- Shared package udma_uart_pkg holds:
  - enum typedef for datasize (DS_BYTE, DS_HALF, DS_WORD);
  - packer FSM state enum (ST_FILL, ST_FLUSH);
  - function mapping datasize to byte count N.
- One sub-module, udma_uart_rx_timeout: the idle counter with compare and pulse output. It is instantiated only under UDMA_UART_RX_TIMEOUT_EN.

## Test plan
- datasize 10, bytes 11,22,33,44 back-to-back, out_ready_i high → single transfer 0x44332211, datasize 10, valid one cycle after the 4th byte.
- datasize 01, out_ready_i low, bytes AA,BB,CC,DD,EE → output holds 0x0000BBAA; byte_cnt_o=2 with DDCC; in_ready_o low at EE. After one out_ready_i cycle, 0xDDCC is emitted and EE is accepted.
- datasize 10, timeout 20, bytes 01,02,03 then idle → timeout_event_o pulses 20 cycles after 03, then transfers 01,02,03 each with datasize 00.
- datasize 10, flush_i coincident with the 2nd byte (5A,A5) → transfers 5A then A5 as bytes; byte_cnt_o returns to 0; in_ready_o low throughout FLUSH.
- cfg_clr_i with a pending output and 3 bytes held → next cycle out_valid_o 0 and byte_cnt_o 0; a following 4-byte burst emits one aligned word.
- Reset asserted in the middle of FLUSH (2 bytes left) → all outputs at reset values immediately; no further transfers after release.
